// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: consumes DIGIT bits per clock,
// LSB slice first, and reports result, carry/borrow and signed overflow on a done pulse.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1,
    parameter bit CHECK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             ci,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic             co,
    output logic             of
);

    // state | meaning
    // IDLE  | waiting for start; r/co/of hold the last result
    // RUN   | one DIGIT-bit slice consumed per clock, LSB slice first
    // FIN   | result just published; done high; start accepted back-to-back

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    generate
        if (CHECK && (WIDTH % DIGIT != 0)) begin : g_digit_check
            $error("addsub_serial: WIDTH must be a multiple of DIGIT");
        end
        if (CHECK && (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH)) begin : g_range_check
            $error("addsub_serial: WIDTH or DIGIT out of range");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] x_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             op_q;
    logic             x_sign;
    logic             b_sign;

    logic [DIGIT:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;

    // b_sh holds the effective addend (y or ~y), so the datapath is always an add
    always_comb begin
        slice_sum = {1'b0, x_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry};
        acc_next  = (acc >> DIGIT)
                  | (WIDTH'(slice_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            x_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            op_q   <= 1'b0;
            x_sign <= 1'b0;
            b_sign <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            r      <= '0;
            co     <= 1'b0;
            of     <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        x_sh   <= x;
                        b_sh   <= op ? ~y : y;
                        acc    <= '0;
                        cnt    <= '0;
                        carry  <= ci ^ op;
                        op_q   <= op;
                        x_sign <= x[WIDTH-1];
                        b_sign <= y[WIDTH-1] ^ op;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    x_sh  <= x_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    acc   <= acc_next;
                    carry <= slice_sum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        r     <= acc_next;
                        // subtract reports a borrow, the inverse of the final carry
                        co    <= slice_sum[DIGIT] ^ op_q;
                        of    <= (x_sign == b_sign) && (acc_next[WIDTH-1] != x_sign);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial: two instances (8/1 and 16/4), directed and
// random operations, expected results from plain-arithmetic reference model.
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic       rst_a_n, start_a, op_a, ci_a, busy_a, done_a, co_a, of_a;
    logic [7:0] x_a, y_a, r_a;
    logic        rst_b_n, start_b, op_b, ci_b, busy_b, done_b, co_b, of_b;
    logic [15:0] x_b, y_b, r_b;

    addsub_serial #(.WIDTH(8), .DIGIT(1), .CHECK(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .start(start_a), .op(op_a), .ci(ci_a),
        .x(x_a), .y(y_a), .busy(busy_a), .done(done_a), .r(r_a), .co(co_a), .of(of_a)
    );

    addsub_serial #(.WIDTH(16), .DIGIT(4), .CHECK(1)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .start(start_b), .op(op_b), .ci(ci_b),
        .x(x_b), .y(y_b), .busy(busy_b), .done(done_b), .r(r_b), .co(co_b), .of(of_b)
    );

    typedef struct {
        logic [15:0] r;
        logic        co;
        logic        of;
        int          at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference: integer arithmetic on the unsigned and signed values of the operands
    function automatic void ref_calc(input int w, input logic op, input logic ci,
                                     input logic [15:0] xv, input logic [15:0] yv,
                                     output logic [15:0] rr, output logic cc, output logic oo);
        longint mask, ux, uy, sx, sy, res_u, res_s, lo, hi;
        mask = (longint'(1) << w) - 1;
        ux = longint'(xv) & mask;
        uy = longint'(yv) & mask;
        sx = xv[w-1] ? ux - (longint'(1) << w) : ux;
        sy = yv[w-1] ? uy - (longint'(1) << w) : uy;
        if (!op) begin
            res_u = ux + uy + longint'(ci);
            res_s = sx + sy + longint'(ci);
            cc = (res_u > mask);
        end else begin
            res_u = ux - uy - longint'(ci);
            res_s = sx - sy - longint'(ci);
            cc = (res_u < 0);
        end
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        rr = 16'(res_u & mask);
        oo = (res_s > hi) || (res_s < lo);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_done: got done=1 expected no done");
            end else begin
                e = qa.pop_front();
                chk("a_r", 64'(r_a), 64'(e.r));
                chk("a_co", 64'(co_a), 64'(e.co));
                chk("a_of", 64'(of_a), 64'(e.of));
                chk("a_latency", 64'(cyc), 64'(e.at));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done_b === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_done: got done=1 expected no done");
            end else begin
                e = qb.pop_front();
                chk("b_r", 64'(r_b), 64'(e.r));
                chk("b_co", 64'(co_b), 64'(e.co));
                chk("b_of", 64'(of_b), 64'(e.of));
                chk("b_latency", 64'(cyc), 64'(e.at));
            end
        end
    end

    task automatic push_a();
        exp_t e;
        ref_calc(8, op_a, ci_a, {8'h00, x_a}, {8'h00, y_a}, e.r, e.co, e.of);
        e.at = cyc + 1 + 8;
        qa.push_back(e);
    endtask

    task automatic push_b();
        exp_t e;
        ref_calc(16, op_b, ci_b, x_b, y_b, e.r, e.co, e.of);
        e.at = cyc + 1 + 4;
        qb.push_back(e);
    endtask

    // ign_at >= 0: pulse start at that wait step; -1: random pulses; other: none
    task automatic wait_done_a(input int ign_at);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_a === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (i == ign_at || (ign_at == -1 && $urandom_range(0, 3) == 0)) begin
                start_a = 1'b1;
                x_a = 8'($urandom);
                y_a = 8'($urandom);
            end
            @(negedge clk);
            start_a = 1'b0;
        end
        start_a = 1'b0;
        chk("a_done_seen", 64'(got), 64'(1));
    endtask

    task automatic wait_done_b(input int ign_at);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_b === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (i == ign_at || (ign_at == -1 && $urandom_range(0, 3) == 0)) begin
                start_b = 1'b1;
                x_b = 16'($urandom);
                y_b = 16'($urandom);
                op_b = 1'($urandom);
            end
            @(negedge clk);
            start_b = 1'b0;
        end
        start_b = 1'b0;
        chk("b_done_seen", 64'(got), 64'(1));
    endtask

    task automatic issue_a(input logic op, input logic ci, input logic [7:0] xv,
                           input logic [7:0] yv, input int ign_at);
        @(negedge clk);
        op_a = op; ci_a = ci; x_a = xv; y_a = yv; start_a = 1'b1;
        push_a();
        @(negedge clk);
        start_a = 1'b0;
        x_a = 8'($urandom); y_a = 8'($urandom); op_a = 1'($urandom); ci_a = 1'($urandom);
        chk("a_busy", 64'(busy_a), 64'(1));
        wait_done_a(ign_at);
    endtask

    task automatic issue_b(input logic op, input logic ci, input logic [15:0] xv,
                           input logic [15:0] yv, input int ign_at);
        @(negedge clk);
        op_b = op; ci_b = ci; x_b = xv; y_b = yv; start_b = 1'b1;
        push_b();
        @(negedge clk);
        start_b = 1'b0;
        x_b = 16'($urandom); y_b = 16'($urandom); op_b = 1'($urandom); ci_b = 1'($urandom);
        chk("b_busy", 64'(busy_b), 64'(1));
        wait_done_b(ign_at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_a_n = 1'b0; start_a = 1'b0; op_a = 1'b0; ci_a = 1'b0; x_a = '0; y_a = '0;
        rst_b_n = 1'b0; start_b = 1'b0; op_b = 1'b0; ci_b = 1'b0; x_b = '0; y_b = '0;
        repeat (3) @(negedge clk);
        chk("a_rst_busy", 64'(busy_a), 64'(0));
        chk("a_rst_done", 64'(done_a), 64'(0));
        chk("a_rst_r", 64'(r_a), 64'(0));
        chk("a_rst_co", 64'(co_a), 64'(0));
        chk("a_rst_of", 64'(of_a), 64'(0));
        chk("b_rst_busy", 64'(busy_b), 64'(0));
        chk("b_rst_r", 64'(r_b), 64'(0));
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;

        // directed 8-bit cases
        issue_a(1'b0, 1'b0, 8'd100, 8'd27, -1);
        issue_a(1'b0, 1'b1, 8'd100, 8'd27, -1);
        issue_a(1'b1, 1'b0, 8'h80, 8'd1, -1);
        issue_a(1'b1, 1'b0, 8'd0, 8'd1, -1);

        // 16/4: start pulse at E2 must be ignored
        issue_b(1'b1, 1'b1, 16'h8000, 16'h0000, 1);

        // back-to-back: start held high through the done cycle
        @(negedge clk);
        op_a = 1'b0; ci_a = 1'b0; x_a = 8'd50; y_a = 8'hFD; start_a = 1'b1;
        push_a();
        @(negedge clk);
        op_a = 1'b1; ci_a = 1'b1; x_a = 8'hF9; y_a = 8'd20;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done_a === 1'b1) begin
                got = 1'b1;
                push_a();
                break;
            end
            @(negedge clk);
        end
        chk("a_b2b_first_done", 64'(got), 64'(1));
        @(negedge clk);
        start_a = 1'b0;
        x_a = 8'h3C; y_a = 8'hC3; op_a = 1'b0; ci_a = 1'b0;
        chk("a_b2b_busy", 64'(busy_a), 64'(1));
        wait_done_a(-2);

        // reset mid-operation aborts with no done
        issue_a(1'b0, 1'b0, 8'd100, 8'd27, -2);
        @(negedge clk);
        op_a = 1'b0; ci_a = 1'b0; x_a = 8'd55; y_a = 8'd9; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_a_n = 1'b0;
        #1;
        chk("a_abort_busy", 64'(busy_a), 64'(0));
        chk("a_abort_done", 64'(done_a), 64'(0));
        chk("a_abort_r", 64'(r_a), 64'(0));
        chk("a_abort_co", 64'(co_a), 64'(0));
        chk("a_abort_of", 64'(of_a), 64'(0));
        repeat (12) @(negedge clk);
        rst_a_n = 1'b1;
        issue_a(1'b0, 1'b1, 8'd17, 8'd38, -1);

        for (int n = 0; n < 25; n++)
            issue_a(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), -1);
        for (int n = 0; n < 25; n++)
            issue_b(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), -1);

        repeat (3) @(negedge clk);
        chk("a_pending", 64'(qa.size()), 64'(0));
        chk("b_pending", 64'(qb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter DIGIT, default 1, meaning bits processed per clock cycle (legal range 1..WIDTH).
REQ-003 The block SHALL have parameter CHECK, default 1, meaning elaboration fails (via $error or equivalent) when WIDTH % DIGIT != 0.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock; it is the only clock.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 The block SHALL have port start  input  1  request to begin an operation.
REQ-007 The block SHALL have port op  input  1  0 = add, 1 = subtract.
REQ-008 The block SHALL have port ci  input  1  carry-in (add) or borrow-in (subtract).
REQ-009 The block SHALL have port x  input  WIDTH  signed two's-complement operand.
REQ-010 The block SHALL have port y  input  WIDTH  signed two's-complement operand.
REQ-011 The block SHALL have port busy  output  1  operation in progress; start ignored.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-013 The block SHALL have port r  output  WIDTH  signed result.
REQ-014 The block SHALL have port co  output  1  carry-out (add) or borrow-out (subtract).
REQ-015 The block SHALL have port of  output  1  signed overflow flag.

Function
REQ-016 For op=0, the block SHALL compute r = x + y + ci mod 2^WIDTH, with co = carry out of bit WIDTH-1.
REQ-017 For op=1, the block SHALL compute r = x - y - ci mod 2^WIDTH, internally as x + ~y + !ci, with co = inverse of that final carry (1 = borrow).
REQ-018 The block SHALL set of = 1 iff the sign of x equals the sign of the effective addend (y for add, ~y for sub) and the sign of r differs from the sign of x.
REQ-019 The FSM SHALL have exactly three states: IDLE, RUN, FIN.
REQ-020 In IDLE or FIN, start=1 at a rising edge SHALL latch x, y, op, ci, clear the digit counter, load the running carry with ci (add) or !ci (sub), and enter RUN.
REQ-021 In RUN, each edge SHALL consume one DIGIT-bit slice, LSB slice first, shift the partial result into r's holding register, and update the running carry.
REQ-022 After the edge that consumes slice WIDTH/DIGIT-1, the FSM SHALL enter FIN and update r, co and of in that same edge.
REQ-023 Latency: with start sampled at edge E0, done SHALL be high for exactly the cycle following edge E(WIDTH/DIGIT).
REQ-024 busy SHALL be 1 exactly while in RUN, and done SHALL be 1 exactly while in FIN for the first cycle only; FIN then returns to IDLE unless start=1.
REQ-025 start=1 while busy=1 SHALL be ignored, with no effect on the latched operands, counter or outputs.
REQ-026 start=1 during the done cycle SHALL be accepted (back-to-back operation), with done still pulsing for one cycle.
REQ-027 r, co and of SHALL hold their last computed values from FIN until the next FIN; they are not valid (may change) while busy=1.
REQ-028 Input changes on x, y, op and ci after the accepting edge SHALL NOT affect the in-flight result.
REQ-029 With DIGIT=WIDTH, the block SHALL complete in one RUN cycle, giving done at E1.

Reset
REQ-030 On rst_n=0, the block SHALL immediately and asynchronously enter IDLE and set busy=0, done=0, r=0, co=0, of=0, with the counter and carry cleared.
REQ-031 Reset asserted mid-operation SHALL abort the operation, with no done pulse produced for it.
REQ-032 After rst_n deasserts, the first start SHALL be sampled no earlier than the first rising edge with rst_n=1.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, DIGIT=1; op=0 ci=0 x=100 y=27 -> done at E8, r=127, co=0, of=0.
REQ-034 The bench SHALL cover: WIDTH=8, DIGIT=1; op=0 ci=1 x=100 y=27 -> r=-128, of=1, co=0.
REQ-035 The bench SHALL cover: WIDTH=8, DIGIT=1; op=1 ci=0 x=-128 y=1 -> r=127, of=1, co=0; and op=1 ci=0 x=0 y=1 -> r=-1, of=0, co=1.
REQ-036 The bench SHALL cover: WIDTH=16, DIGIT=4; op=1 ci=1 x=-32768 y=0 -> done at E4, r=32767, of=1; start pulsed at E2 is ignored.
REQ-037 The bench SHALL cover: back-to-back operation, with start held high through the done cycle -> second done at exactly E8 after the first; operands changed after acceptance do not alter r.
REQ-038 The bench SHALL cover: rst_n pulsed low at E3 of an operation -> busy=0, r=0, no done; a fresh start then completes normally.
